// File: rtl/alu_operand_loader.sv
// Button-driven operand loader feeding OP1, OP2 and OPCODE to a combinational ALU.
// Define ALU_LOADER_DEBOUNCE_EN to build the debounce counter; otherwise the synchronised button is used as-is.
module alu_operand_loader #(
  parameter int opcodeBus      = 6,
  parameter int dataBus        = 8,
  parameter int debounceCycles = 500000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [dataBus-1:0]   SW,
  input  logic                 BTN,
  output logic [dataBus-1:0]   OP1,
  output logic [dataBus-1:0]   OP2,
  output logic [opcodeBus-1:0] OPCODE,
  output logic                 VALID,
  output logic [1:0]           STATE
);

  // state | meaning
  // S_OP1 | waiting for the press that captures operand 1
  // S_OP2 | waiting for the press that captures operand 2
  // S_OPC | waiting for the press that captures the opcode
  // S_RUN | complete set held for the ALU, VALID high
  typedef enum logic [1:0] {
    S_OP1 = 2'b00,
    S_OP2 = 2'b01,
    S_OPC = 2'b10,
    S_RUN = 2'b11
  } state_t;

  if (opcodeBus > dataBus) begin : g_bad_opcode_width
    $error("alu_operand_loader: opcodeBus must not exceed dataBus");
  end
  if (debounceCycles < 1) begin : g_bad_debounce
    $error("alu_operand_loader: debounceCycles must be at least 1");
  end

  logic   s1;
  logic   s2;
  logic   filt;
  logic   filt_d;
  logic   press;
  state_t state;

  // BTN is fully asynchronous, so it gets a plain two-flop synchroniser.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(debounceCycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounceCycles - 1);

  logic [CNT_W-1:0] cnt;

  // Any sample agreeing with the filtered level restarts the stability window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign filt = s2;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_d <= 1'b0;
    end else begin
      filt_d <= filt;
    end
  end

  assign press = filt & ~filt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_OP1;
      OP1    <= '0;
      OP2    <= '0;
      OPCODE <= '0;
      VALID  <= 1'b0;
    end else if (press) begin
      case (state)
        S_OP1: begin
          OP1   <= SW;
          state <= S_OP2;
        end
        S_OP2: begin
          OP2   <= SW;
          state <= S_OPC;
        end
        S_OPC: begin
          OPCODE <= SW[opcodeBus-1:0];
          VALID  <= 1'b1;
          state  <= S_RUN;
        end
        S_RUN: begin
          // Old operands stay visible until overwritten by the next sequence.
          VALID <= 1'b0;
          state <= S_OP1;
        end
        default: state <= S_OP1;
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with debounceCycles = 4; expectations follow
// whichever build (ALU_LOADER_DEBOUNCE_EN defined or not) is being compiled.
module tb_alu_operand_loader;

  localparam int DB = 4;
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SW  = 8'h00;
  logic       BTN = 1'b0;
  logic [7:0] OP1;
  logic [7:0] OP2;
  logic [5:0] OPCODE;
  logic       VALID;
  logic [1:0] STATE;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(
    .opcodeBus(6),
    .dataBus(8),
    .debounceCycles(DB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SW(SW),
    .BTN(BTN),
    .OP1(OP1),
    .OP2(OP2),
    .OPCODE(OPCODE),
    .VALID(VALID),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [5:0] opc;
    logic       valid;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] op1, input logic [7:0] op2,
                           input logic [5:0] opc, input logic valid, input logic [1:0] state);
    check({tag, " OP1"}, 32'(OP1), 32'(op1));
    check({tag, " OP2"}, 32'(OP2), 32'(op2));
    check({tag, " OPCODE"}, 32'(OPCODE), 32'(opc));
    check({tag, " VALID"}, 32'(VALID), 32'(valid));
    check({tag, " STATE"}, 32'(STATE), 32'(state));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    BTN = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic do_press(input logic [7:0] sw);
    SW  = sw;
    BTN = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    BTN = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    logic [1:0] prev_state;
    logic [4:0] bounce;

    vecs[0] = '{sw: 8'h2A, op1: 8'h2A, op2: 8'h00, opc: 6'h00, valid: 1'b0, state: 2'b01};
    vecs[1] = '{sw: 8'h15, op1: 8'h2A, op2: 8'h15, opc: 6'h00, valid: 1'b0, state: 2'b10};
    vecs[2] = '{sw: 8'h20, op1: 8'h2A, op2: 8'h15, opc: 6'h20, valid: 1'b1, state: 2'b11};
    vecs[3] = '{sw: 8'h77, op1: 8'h2A, op2: 8'h15, opc: 6'h20, valid: 1'b0, state: 2'b00};

    // reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check_all("idle", 8'h00, 8'h00, 6'h00, 1'b0, 2'b00);

    // table: clean presses, capture edge checked on every cycle of the high phase
    prev_state = 2'b00;
    for (int v = 0; v < 4; v++) begin
      SW  = vecs[v].sw;
      BTN = 1'b1;
      for (int e = 1; e <= 8; e++) begin
        tick();
        if (e == LAT - 1) check($sformatf("vec%0d pre-capture STATE", v), 32'(STATE), 32'(prev_state));
        if (e == LAT)     check($sformatf("vec%0d capture STATE", v), 32'(STATE), 32'(vecs[v].state));
        if (e == 8)       check($sformatf("vec%0d held STATE", v), 32'(STATE), 32'(vecs[v].state));
      end
      BTN = 1'b0;
      SW  = ~vecs[v].sw;
      for (int i = 0; i < 8; i++) tick();
      check_all($sformatf("vec%0d", v), vecs[v].op1, vecs[v].op2, vecs[v].opc,
                vecs[v].valid, vecs[v].state);
      prev_state = vecs[v].state;
    end

    // reset at edge 3 of a press: no capture, everything back to zero
    SW  = 8'h5A;
    BTN = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    BTN = 1'b0;
    check_all("mid-reset", 8'h00, 8'h00, 6'h00, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) tick();
    check_all("post-reset", 8'h00, 8'h00, 6'h00, 1'b0, 2'b00);

    // bouncing press in S_OP1: 1,0,1,1,0 then steady high for 10 cycles
    bounce = 5'b01101;
    SW = 8'h55;
    for (int e = 1; e <= 15; e++) begin
      BTN = (e <= 5) ? bounce[e-1] : 1'b1;
      tick();
`ifdef ALU_LOADER_DEBOUNCE_EN
      if (e == 11) check("bounce no early capture", 32'(STATE), 32'(2'b00));
      if (e == 12) check("bounce capture edge", 32'(STATE), 32'(2'b01));
`else
      if (e == 3) check("bounce first capture", 32'(STATE), 32'(2'b01));
`endif
    end
    BTN = 1'b0;
    for (int i = 0; i < 10; i++) tick();
`ifdef ALU_LOADER_DEBOUNCE_EN
    check_all("bounce", 8'h55, 8'h00, 6'h00, 1'b0, 2'b01);
`else
    check_all("bounce", 8'h55, 8'h55, 6'h15, 1'b1, 2'b11);
`endif

    // long hold in S_OP2 gives one capture; SW changes after capture are ignored
    do_reset();
    do_press(8'h01);
    check("hold setup STATE", 32'(STATE), 32'(2'b01));
    SW  = 8'h66;
    BTN = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (e == LAT) check("hold capture STATE", 32'(STATE), 32'(2'b10));
      if (e == 20) SW = 8'h99;
    end
    check("hold end STATE", 32'(STATE), 32'(2'b10));
    BTN = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check_all("hold", 8'h01, 8'h66, 6'h00, 1'b0, 2'b10);

    // button held through reset release counts as a fresh press
    RST = 1'b1;
    BTN = 1'b1;
    SW  = 8'h11;
    for (int i = 0; i < 3; i++) tick();
    check_all("held reset", 8'h00, 8'h00, 6'h00, 1'b0, 2'b00);
    RST = 1'b0;
    for (int e = 1; e <= LAT + 2; e++) begin
      tick();
      if (e == LAT - 1) check("held-through pre STATE", 32'(STATE), 32'(2'b00));
      if (e == LAT)     check("held-through capture STATE", 32'(STATE), 32'(2'b01));
    end
    BTN = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check_all("held-through", 8'h11, 8'h00, 6'h00, 1'b0, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
